// File: rtl/drive_event_pkg.sv
// Shared types and constants for the drive-event generator.
//   drive_state_t : sequencing states of the generator FSM
//   DRIVE_RISE/FALL: encoding of i_sel_rise_fall
package drive_event_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HOLD,
    DONE
  } drive_state_t;

  localparam logic DRIVE_RISE = 1'b1;
  localparam logic DRIVE_FALL = 1'b0;

endpackage

// File: rtl/drive_event_cnt.sv
// 32-bit loadable down-counter with a zero flag.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : load load_val_i this cycle (takes priority over en_i)
//   load_val_i   : value to load
//   en_i         : decrement by one; saturates at zero, never wraps
//   zero_o       : count is zero
module drive_event_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        en_i,
  output logic        zero_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 32'd1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/drive_event_tb.sv
// Testbench-side event generator. On a start request it drives o_drive[sel] to all-ones (rise)
// or all-zeros (fall) after i_delay cycles, then either leaves it (i_hold = 0) or restores the
// previous value after i_hold further cycles.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_en_drive_event  : one-cycle start request, accepted in IDLE or in the DONE cycle
//   i_drive_sel       : index of the entry to drive
//   i_sel_rise_fall   : 1 = rise, 0 = fall
//   i_delay, i_hold   : cycles to the edge / pulse length (0 = step)
//   o_drive           : registered array of driven signals
//   o_busy            : high from the cycle after start through the done cycle
//   o_drive_done      : one-cycle completion pulse
//   o_error           : pulses with done when the index was out of range
module drive_event_tb
  import drive_event_pkg::*;
#(
  parameter int unsigned DRIVE_SIZE  = 5,
  parameter int unsigned DRIVE_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en_drive_event,
  input  logic [31:0]            i_drive_sel,
  input  logic                   i_sel_rise_fall,
  input  logic [31:0]            i_delay,
  input  logic [31:0]            i_hold,
  output logic [DRIVE_WIDTH-1:0] o_drive [DRIVE_SIZE],
  output logic                   o_busy,
  output logic                   o_drive_done,
  output logic                   o_error
);

  drive_state_t state_q, state_d;

  logic [31:0]            sel_q, hold_q;
  logic                   rise_q, inval_q;
  logic [DRIVE_WIDTH-1:0] restore_q, cur_val, wr_val;
  logic                   start, sel_ok;
  logic                   cnt_load, cnt_en, cnt_zero;
  logic [31:0]            cnt_val;
  logic                   wr_en, done_d, err_d, busy_d;

  // Current value of the requested entry, captured as the restore value at start.
  always_comb begin
    cur_val = '0;
    for (int i = 0; i < DRIVE_SIZE; i++) begin
      if (i_drive_sel == 32'(i)) cur_val = o_drive[i];
    end
  end

  assign sel_ok = (i_drive_sel < DRIVE_SIZE);
  // The DONE cycle accepts a new start so events can run back-to-back.
  assign start  = i_en_drive_event && ((state_q == IDLE) || (state_q == DONE));

  drive_event_cnt u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    wr_en    = 1'b0;
    wr_val   = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    busy_d   = (state_q == DELAY) || (state_q == HOLD);
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Invalid index loads zero so it completes on the very next edge without a write.
          cnt_load = 1'b1;
          cnt_val  = sel_ok ? i_delay : 32'd0;
          state_d  = DELAY;
        end else begin
          state_d  = IDLE;
        end
      end
      DELAY: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (inval_q) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wr_en  = 1'b1;
          wr_val = (rise_q == DRIVE_RISE) ? {DRIVE_WIDTH{1'b1}} : '0;
          if (hold_q == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Expiry edge itself is the last hold cycle, hence hold - 1.
            cnt_load = 1'b1;
            cnt_val  = hold_q - 32'd1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_val  = restore_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      hold_q       <= '0;
      rise_q       <= 1'b0;
      inval_q      <= 1'b0;
      restore_q    <= '0;
      o_busy       <= 1'b0;
      o_drive_done <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_busy       <= busy_d;
      o_drive_done <= done_d;
      o_error      <= err_d;
      if (start) begin
        sel_q     <= i_drive_sel;
        hold_q    <= i_hold;
        rise_q    <= i_sel_rise_fall;
        inval_q   <= !sel_ok;
        restore_q <= cur_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DRIVE_SIZE; i++) o_drive[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DRIVE_SIZE; i++) begin
        if (sel_q == 32'(i)) o_drive[i] <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_drive_event_tb.sv
// Self-checking bench for drive_event_tb: two instances (width 1 and 8) share one stimulus
// stream; each is checked every cycle against a timeline model of scheduled events.
module tb_drive_event_tb;

  localparam int unsigned N = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] sel = '0;
  logic        rf = 1'b0;
  logic [31:0] delay = '0;
  logic [31:0] hold = '0;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned W = (g == 0) ? 1 : 8;

    logic [W-1:0] drive [N];
    logic         busy, done, err;

    drive_event_tb #(
      .DRIVE_SIZE  (N),
      .DRIVE_WIDTH (W)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_en_drive_event (en),
      .i_drive_sel      (sel),
      .i_sel_rise_fall  (rf),
      .i_delay          (delay),
      .i_hold           (hold),
      .o_drive          (drive),
      .o_busy           (busy),
      .o_drive_done     (done),
      .o_error          (err)
    );

    // Model: one job described by absolute cycle numbers of its edge and its completion.
    logic [W-1:0] m_drive [N];
    bit           m_busy, m_done, m_err;
    bit           job = 0;
    bit           j_err, j_pulse;
    int unsigned  cyc = 0;
    int unsigned  t0, t_edge, t_end, j_sel;
    logic [W-1:0] j_lvl, j_rest;

    initial begin
      forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
          job = 0;
          for (int i = 0; i < N; i++) m_drive[i] = '0;
          m_busy = 0;
          m_done = 0;
          m_err  = 0;
        end else begin
          if (job && cyc <= t_end) begin
            if (!j_err && cyc == t_edge) m_drive[j_sel] = j_lvl;
            if (!j_err && j_pulse && cyc == t_end) m_drive[j_sel] = j_rest;
          end else if (en) begin
            job     = 1;
            t0      = cyc;
            j_err   = (sel >= N);
            j_sel   = j_err ? 0 : int'(sel);
            j_lvl   = rf ? {W{1'b1}} : '0;
            j_rest  = m_drive[j_sel];
            j_pulse = (hold != 0);
            t_edge  = cyc + 1 + delay;
            t_end   = j_err ? cyc + 1 : cyc + 1 + delay + hold;
          end
          m_busy = job && cyc >= t0 + 1 && cyc <= t_end;
          m_done = job && cyc == t_end;
          m_err  = m_done && j_err;
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          check($sformatf("w%0d c%0d drive[%0d]", W, cyc, i), 32'(drive[i]),
                rst_n ? 32'(m_drive[i]) : 32'd0);
        end
        check($sformatf("w%0d c%0d busy", W, cyc), 32'(busy), rst_n ? 32'(m_busy) : 32'd0);
        check($sformatf("w%0d c%0d done", W, cyc), 32'(done), rst_n ? 32'(m_done) : 32'd0);
        check($sformatf("w%0d c%0d error", W, cyc), 32'(err), rst_n ? 32'(m_err) : 32'd0);
      end
    end
  end

  // Advance to 2 time units after the k-th following rising edge.
  task automatic go(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Called 2 units after an edge; returns 2 units after the sampling edge T.
  task automatic start(input int s, input bit r, input int d, input int h);
    en    = 1'b1;
    sel   = 32'(s);
    rf    = r;
    delay = 32'(d);
    hold  = 32'(h);
    go(1);
    en    = 1'b0;
  endtask

  initial begin
    go(3);
    rst_n = 1'b1;
    go(1);
    check("reset busy", 32'(g_inst[0].busy), 32'd0);

    // Rise step, sel 2, D=0
    start(2, 1, 0, 0);
    go(1);
    check("t1 drive2", 32'(g_inst[0].drive[2]), 32'd1);
    check("t1 done", 32'(g_inst[0].done), 32'd1);
    check("t1 drive1", 32'(g_inst[0].drive[1]), 32'd0);
    go(3);
    check("t1 drive2 kept", 32'(g_inst[0].drive[2]), 32'd1);

    // Fall pulse, sel 2, D=3, H=4
    start(2, 0, 3, 4);
    go(3);
    check("t2 drive2 T+3", 32'(g_inst[0].drive[2]), 32'd1);
    check("t2 busy T+3", 32'(g_inst[0].busy), 32'd1);
    go(1);
    check("t2 drive2 T+4", 32'(g_inst[0].drive[2]), 32'd0);
    check("t2 done T+4", 32'(g_inst[0].done), 32'd0);
    go(4);
    check("t2 drive2 T+8", 32'(g_inst[0].drive[2]), 32'd1);
    check("t2 done T+8", 32'(g_inst[0].done), 32'd1);
    go(1);
    check("t2 busy T+9", 32'(g_inst[0].busy), 32'd0);

    // Out-of-range index
    start(7, 1, 0, 0);
    go(1);
    check("t3 error", 32'(g_inst[0].err), 32'd1);
    check("t3 done", 32'(g_inst[0].done), 32'd1);
    check("t3 busy", 32'(g_inst[0].busy), 32'd1);
    go(1);
    check("t3 busy after", 32'(g_inst[0].busy), 32'd0);

    // Start during DELAY is ignored; start in the done cycle is accepted
    start(1, 1, 3, 0);
    go(1);
    start(3, 1, 0, 0);
    go(1);
    check("t4 no early done", 32'(g_inst[0].done), 32'd0);
    go(1);
    check("t4 done T+4", 32'(g_inst[0].done), 32'd1);
    check("t4 drive3 untouched", 32'(g_inst[0].drive[3]), 32'd0);
    start(3, 1, 0, 0);
    go(1);
    check("t4 back-to-back done", 32'(g_inst[0].done), 32'd1);
    check("t4 drive3", 32'(g_inst[0].drive[3]), 32'd1);

    // Reset mid-HOLD of a rise pulse on sel 0
    go(1);
    start(0, 1, 2, 10);
    go(3);
    check("t5 drive0 high", 32'(g_inst[0].drive[0]), 32'd1);
    go(3);
    rst_n = 1'b0;
    #1;
    check("t5 reset drive0", 32'(g_inst[0].drive[0]), 32'd0);
    check("t5 reset drive3", 32'(g_inst[0].drive[3]), 32'd0);
    check("t5 reset busy", 32'(g_inst[0].busy), 32'd0);
    go(2);
    rst_n = 1'b1;
    go(1);
    start(0, 1, 1, 0);
    go(1);
    check("t5 step done T+1", 32'(g_inst[0].done), 32'd0);
    go(1);
    check("t5 step done T+2", 32'(g_inst[0].done), 32'd1);
    check("t5 step drive0", 32'(g_inst[0].drive[0]), 32'd1);

    // Width 8: rise then fall step on sel 4
    go(1);
    start(4, 1, 2, 0);
    go(3);
    check("t6 w8 rise", 32'(g_inst[1].drive[4]), 32'h0000_00ff);
    check("t6 w8 rise done", 32'(g_inst[1].done), 32'd1);
    go(1);
    start(4, 0, 0, 0);
    go(1);
    check("t6 w8 fall", 32'(g_inst[1].drive[4]), 32'd0);
    check("t6 w8 fall done", 32'(g_inst[1].done), 32'd1);
    go(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
